// File: rtl/float_result_stage.sv
// Output stage for a float divider: saturates over/underflowed quotients, queues them in a
// 2-entry FIFO with their flags, and keeps sticky flags and a count of consumed results.
module float_result_stage #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] in_float,
  input  logic                  in_overflow,
  input  logic                  in_underflow,
  input  logic                  in_inexact,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out_float,
  output logic [2:0]            out_flags,
  output logic [2:0]            sticky_flags,
  input  logic                  flags_clear,
  output logic [15:0]           result_count
);

  typedef struct packed {
    logic [FLOAT_SIZE-1:0] fp;
    logic [2:0]            flg;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wptr, r_rptr;
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic [2:0]  r_sticky;
  logic [15:0] r_res_cnt;

  logic        w_acc, w_pop;
  logic [1:0]  w_cnt_nxt;
  logic [2:0]  w_flags;
  logic [2:0]  w_sticky_nxt;
  entry_t      w_entry;

  assign w_flags = {in_overflow, in_underflow, in_inexact};

  // Underflow wins when both flags are set; the stored flags are never altered.
  always_comb begin
    w_entry.flg = w_flags;
    w_entry.fp  = in_float;
    if (in_underflow)
      w_entry.fp = {in_float[FLOAT_SIZE-1], {(FLOAT_SIZE-1){1'b0}}};
    else if (in_overflow)
      w_entry.fp = {in_float[FLOAT_SIZE-1], {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
  end

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = out_valid & out_ready;

  always_comb begin
    case ({w_acc, w_pop})
      2'b10:   w_cnt_nxt = r_count + 2'd1;
      2'b01:   w_cnt_nxt = r_count - 2'd1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_comb begin
    w_sticky_nxt = flags_clear ? 3'b000 : r_sticky;
    if (w_acc) w_sticky_nxt = w_sticky_nxt | w_flags;
  end

  // in_ready is registered from the next occupancy so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
      r_sticky   <= 3'b000;
      r_res_cnt  <= 16'd0;
    end else begin
      if (w_acc) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr    <= ~r_rptr;
        r_res_cnt <= r_res_cnt + 16'd1;
      end
      r_count    <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt != 2'd2);
      r_sticky   <= w_sticky_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_count != 2'd0);
  assign out_float    = r_mem[r_rptr].fp;
  assign out_flags    = r_mem[r_rptr].flg;
  assign sticky_flags = r_sticky;
  assign result_count = r_res_cnt;

endmodule

// File: tb/tb_float_result_stage.sv
// Scoreboard bench for float_result_stage: a queue-based reference model tracks the FIFO,
// sticky flags and consumed-result count; directed cases plus randomized traffic.
module tb_float_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_float = '0;
  logic        in_overflow = 1'b0, in_underflow = 1'b0, in_inexact = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_float;
  logic [2:0]  out_flags;
  logic [2:0]  sticky_flags;
  logic        flags_clear = 1'b0;
  logic [15:0] result_count;

  float_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_float(in_float),
    .in_overflow(in_overflow), .in_underflow(in_underflow), .in_inexact(in_inexact),
    .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float),
    .out_flags(out_flags), .sticky_flags(sticky_flags), .flags_clear(flags_clear),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds {float, overflow, underflow, inexact}.
  logic [34:0] q[$];
  logic [2:0]  m_sticky = 3'b000;
  logic [15:0] m_rc = 16'd0;
  bit          up = 1'b0;   // a clock edge has been seen since reset released

  function automatic logic [31:0] sat(input logic [31:0] f, input logic of, input logic uf);
    if (uf) return f & 32'h8000_0000;
    if (of) return (f & 32'h8000_0000) | 32'h7F80_0000;
    return f;
  endfunction

  always @(negedge rst_n) up = 1'b0;
  always @(posedge clk) if (rst_n) up = 1'b1;

  initial begin : monitor
    bit acc, pop;
    logic [2:0] fl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_sticky = 3'b000;
        m_rc     = 16'd0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(up && q.size() != 2));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("sticky_flags", 64'(sticky_flags), 64'(m_sticky));
        check("result_count", 64'(result_count), 64'(m_rc));
        if (q.size() != 0) begin
          check("out_float", 64'(out_float), 64'(q[0][34:3]));
          check("out_flags", 64'(out_flags), 64'(q[0][2:0]));
        end
        acc = in_valid && up && q.size() != 2;
        pop = q.size() != 0 && out_ready;
        fl  = {in_overflow, in_underflow, in_inexact};
        if (pop) begin
          void'(q.pop_front());
          m_rc = m_rc + 16'd1;
        end
        if (acc) q.push_back({sat(in_float, in_overflow, in_underflow), fl});
        if (flags_clear) m_sticky = 3'b000;
        if (acc) m_sticky = m_sticky | fl;
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] f, input logic of, input logic uf,
                     input logic ix, input logic ordy, input logic clr);
    in_valid = v; in_float = f; in_overflow = of; in_underflow = uf; in_inexact = ix;
    out_ready = ordy; flags_clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flags_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    // Reset values
    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_float", 64'(out_float), 64'd0);
    check("rst out_flags", 64'(out_flags), 64'd0);
    check("rst sticky", 64'(sticky_flags), 64'd0);
    check("rst result_count", 64'(result_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("in_ready before edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("in_ready after edge", 64'(in_ready), 64'd1);

    // Plain result, one-cycle latency
    cyc(1, 32'h3F80_0000, 0, 0, 0, 1, 0);
    check("lat out_valid", 64'(out_valid), 64'd1);
    check("lat out_float", 64'(out_float), 64'h3F80_0000);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("first result_count", 64'(result_count), 64'd1);

    // Overflow saturation
    cyc(1, 32'h80FF_1234, 1, 0, 0, 1, 0);
    check("ovf out_float", 64'(out_float), 64'hFF80_0000);
    check("ovf out_flags", 64'(out_flags), 64'b100);
    check("ovf sticky", 64'(sticky_flags), 64'b100);

    // Both flags -> underflow saturation, both flags kept
    cyc(1, 32'h0012_3456, 1, 1, 0, 1, 0);
    check("unf out_float", 64'(out_float), 64'h0000_0000);
    check("unf out_flags", 64'(out_flags), 64'b110);

    // Sticky clear behaviour
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(1, 32'h4000_0000, 1, 0, 1, 1, 0);
    check("sticky 101", 64'(sticky_flags), 64'b101);
    cyc(1, 32'h4040_0000, 0, 1, 0, 1, 1);
    check("clear+accept", 64'(sticky_flags), 64'b010);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("clear alone", 64'(sticky_flags), 64'b000);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Back-pressure: fill, blocked third push, ordered drain
    cyc(1, 32'h1111_1111, 0, 0, 0, 0, 0);
    cyc(1, 32'h2222_2222, 0, 0, 1, 0, 0);
    check("full in_ready", 64'(in_ready), 64'd0);
    cyc(1, 32'h3333_3333, 0, 0, 0, 0, 0);
    check("hold out_float", 64'(out_float), 64'h1111_1111);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("drain B", 64'(out_float), 64'h2222_2222);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("drained", 64'(out_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom(), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 6, $urandom_range(0, 7) == 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Counter wrap after 65537 consumed results
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1, $urandom(), 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("wrap result_count", 64'(result_count), 64'h0001);

    // Asynchronous reset with two entries queued
    cyc(1, 32'hAAAA_AAAA, 0, 0, 1, 0, 0);
    cyc(1, 32'hBBBB_BBBB, 1, 0, 0, 0, 0);
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async in_ready", 64'(in_ready), 64'd0);
    check("async out_float", 64'(out_float), 64'd0);
    check("async sticky", 64'(sticky_flags), 64'd0);
    check("async result_count", 64'(result_count), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_result_stage.md
FLOAT_RESULT_STAGE -- requirements
Module: float_result_stage

Interface
REQ-001 Parameter FLOAT_SIZE, default 32, total float bit-length.
REQ-002 Parameter EXPONENT_SIZE, default 8, exponent field bit-length.
REQ-003 Parameter MANTISSA_SIZE, default 23, mantissa field bit-length; FLOAT_SIZE SHALL equal 1+EXPONENT_SIZE+MANTISSA_SIZE.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream divider result valid.
REQ-007 in_ready  output  1  stage can accept a result this cycle.
REQ-008 in_float  input  FLOAT_SIZE  raw quotient {S|E|M} from divider.
REQ-009 in_overflow, in_underflow, in_inexact  input  1 each  divider flags for in_float.
REQ-010 out_valid  output  1  out_float/out_flags hold a result.
REQ-011 out_ready  input  1  downstream consumes result.
REQ-012 out_float  output  FLOAT_SIZE  saturated result.
REQ-013 out_flags  output  3  {overflow, underflow, inexact} of the head result.
REQ-014 sticky_flags  output  3  accumulated {overflow, underflow, inexact} since last clear.
REQ-015 flags_clear  input  1  synchronous clear of sticky_flags.
REQ-016 result_count  output  16  number of results consumed downstream, wrapping.

Function
REQ-017 Accept SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-018 Storage SHALL be a 2-entry FIFO (float + 3 flags per entry), with occupancy count 0..2.
REQ-019 in_ready SHALL equal (count != 2), driven from registered state only, no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_float/out_flags SHALL present the head entry.
REQ-021 Latency: a result accepted in cycle N with FIFO empty SHALL appear on out_float in cycle N+1.
REQ-022 Accept and pop in same cycle at count 1 SHALL leave count 1 with the new entry at head; at count 2 accept is blocked.
REQ-023 Entries SHALL leave in acceptance order; read/write pointers SHALL wrap 1->0.
REQ-024 Saturation, applied at accept: in_underflow=1 -> {sign, all-zero exponent, zero mantissa}; else in_overflow=1 -> {sign, all-ones exponent, zero mantissa}; else in_float unchanged.
REQ-025 Both in_overflow and in_underflow set SHALL be treated as underflow for saturation; both flags SHALL still be stored.
REQ-026 sticky_flags SHALL OR in the flags of every accepted result, in the accept cycle's edge.
REQ-027 flags_clear with no accept SHALL zero sticky_flags; flags_clear with accept SHALL load exactly the accepted flags.
REQ-028 result_count SHALL increment by 1 per pop, 0xFFFF -> 0x0000.
REQ-029 in_valid with in_ready=0 SHALL not alter any state; upstream holds its data.
REQ-030 out_float/out_flags SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-031 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=0, sticky_flags=0, result_count=0, out_float=0, out_flags=0.
REQ-032 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all stored entries immediately, without waiting for clk.

Verification
REQ-034 Reset, then accept 0x3F800000 with flags 000, out_ready=1 -> out_valid cycle N+1, out_float=0x3F800000, result_count=1.
REQ-035 Accept 0x80FF1234 with in_overflow=1 -> out_float=0xFF800000, out_flags=100, sticky_flags=100.
REQ-036 Accept 0x00123456 with in_underflow=1 and in_overflow=1 -> out_float=0x00000000, out_flags=110.
REQ-037 out_ready=0, push A,B -> in_ready=0 after 2 accepts; third in_valid ignored; release -> A then B out, count back to 0.
REQ-038 sticky_flags=101, flags_clear=1 with accept of flags 010 -> sticky_flags=010; flags_clear alone -> 000.
REQ-039 Hold out_ready=1, stream 65537 results -> result_count=0x0001 (wrap); rst_n pulse with 2 entries queued -> out_valid=0 immediately.
